// File: rtl/matrix_loader.sv
// Byte-stream sequencer for the 2x2 NN predictor: loads three 2x2 matrices, then captures the decision.
// Optional trailing XOR checksum byte is enabled with MATRIX_LOADER_CHECKSUM_EN.
module matrix_loader #(
    parameter int SETTLE_CYCLES = 3,
    parameter int NUM_MATS      = 3,
    parameter int ENTRIES       = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [1:0]  mat_sel,
    output logic [1:0]  adr,
    output logic [20:0] w2,
    input  logic [2:0]  decision_in,
    output logic [2:0]  result,
    output logic        result_valid,
    output logic        busy,
    output logic        err
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SET_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [1:0]    ENT_LAST = 2'(ENTRIES - 1);
    localparam logic [1:0]    MAT_LAST = 2'(NUM_MATS - 1);

`ifdef MATRIX_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, RECV, WRITE, SETTLE, CSUM} state_t;
    logic [7:0] csum;
`else
    typedef enum logic [2:0] {IDLE, RECV, WRITE, SETTLE} state_t;
`endif

    state_t state, state_nxt;
    logic [1:0]    byte_cnt, ent_idx, mat_idx;
    logic [15:0]   word_lo;
    logic [SW-1:0] settle_cnt;
    logic          last_word;

    assign last_word = (mat_idx == MAT_LAST) && (ent_idx == ENT_LAST);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (start) state_nxt = RECV;
            RECV:   if (in_valid && byte_cnt == 2'd2) state_nxt = WRITE;
`ifdef MATRIX_LOADER_CHECKSUM_EN
            WRITE:  if (last_word) state_nxt = CSUM; else state_nxt = RECV;
            CSUM:   if (in_valid) state_nxt = (in_data == csum) ? SETTLE : IDLE;
`else
            WRITE:  if (last_word) state_nxt = SETTLE; else state_nxt = RECV;
`endif
            SETTLE: if (settle_cnt == SET_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        mat_sel  = 2'b11;
        busy     = (state != IDLE);
        case (state)
            RECV:  in_ready = 1'b1;
            WRITE: mat_sel  = mat_idx;
`ifdef MATRIX_LOADER_CHECKSUM_EN
            CSUM:  in_ready = 1'b1;
`endif
            default: ;
        endcase
    end

    // adr/w2 are loaded with the third byte so they are stable throughout WRITE and hold afterwards.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            byte_cnt     <= '0;
            word_lo      <= '0;
            ent_idx      <= '0;
            mat_idx      <= '0;
            settle_cnt   <= '0;
            adr          <= '0;
            w2           <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    result_valid <= 1'b0;
                    byte_cnt     <= '0;
                    ent_idx      <= '0;
                    mat_idx      <= '0;
                    settle_cnt   <= '0;
                end
                RECV: if (in_valid) begin
                    case (byte_cnt)
                        2'd0: begin word_lo[7:0]  <= in_data; byte_cnt <= 2'd1; end
                        2'd1: begin word_lo[15:8] <= in_data; byte_cnt <= 2'd2; end
                        default: begin
                            w2       <= {in_data[4:0], word_lo};
                            adr      <= ent_idx;
                            byte_cnt <= 2'd0;
                        end
                    endcase
                end
                WRITE: begin
                    settle_cnt <= '0;
                    if (ent_idx == ENT_LAST) begin
                        ent_idx <= '0;
                        mat_idx <= last_word ? 2'd0 : mat_idx + 2'd1;
                    end else begin
                        ent_idx <= ent_idx + 2'd1;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == SET_LAST) begin
                        result       <= decision_in;
                        result_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MATRIX_LOADER_CHECKSUM_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            csum <= '0;
            err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin csum <= '0; err <= 1'b0; end
                RECV: if (in_valid) csum <= csum ^ in_data;
                CSUM: if (in_valid && in_data != csum) err <= 1'b1;
                default: ;
            endcase
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: reset, basic load, sign/width, stall, ignored start, checksum.
module tb_matrix_loader;
    logic        clk = 1'b0;
    logic        rst, start, in_valid;
    logic [7:0]  in_data;
    logic [2:0]  decision_in;
    logic        in_ready, result_valid, busy, err;
    logic [1:0]  mat_sel, adr;
    logic [20:0] w2;
    logic [2:0]  result;

    matrix_loader dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mat_sel(mat_sel), .adr(adr), .w2(w2), .decision_in(decision_in),
        .result(result), .result_valid(result_valid), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [1:0] sel; logic [1:0] a; logic [20:0] w; int c; } wr_t;
    wr_t wq[$];
    always @(negedge clk) if (mat_sel !== 2'b11) wq.push_back('{mat_sel, adr, w2, cyc});

    typedef logic [20:0] warr_t [12];
    typedef logic [7:0]  barr_t [36];

    int cmp = 0, errs = 0;
    logic [7:0] xsum;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic barr_t mk(input warr_t w);
        barr_t b;
        for (int i = 0; i < 12; i++) begin
            b[3*i]   = w[i][7:0];
            b[3*i+1] = w[i][15:8];
            b[3*i+2] = {3'b000, w[i][20:16]};
        end
        return b;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (n < 50) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        chk("byte_accept", {31'b0, in_ready}, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        xsum = xsum ^ b;
    endtask

    // rpulse: byte index before which start is pulsed in RECV (-1 = none); spulse: pulse start in SETTLE.
    task automatic run(input barr_t b, input bit stall, input int rpulse, input bit spulse, output int rv_cyc);
        int n = 0;
        logic [7:0] c;
        xsum = 8'h00;
        wq.delete();
        in_data = b[0]; in_valid = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("rv_cleared", {31'b0, result_valid}, 0);
        for (int i = 0; i < 36; i++) begin
            if (i == rpulse) begin
                in_valid = 1'b0; start = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                chk("busy_recv_pulse", {31'b0, busy}, 1);
            end
            send_byte(b[i]);
            if (stall) begin @(posedge clk); #1; end
        end
`ifdef MATRIX_LOADER_CHECKSUM_EN
        c = xsum;
        send_byte(c);
`endif
        if (spulse) begin
            @(posedge clk); #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            chk("busy_settle_pulse", {31'b0, busy}, 1);
        end
        while (!result_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        rv_cyc = cyc;
        chk("rv_set", {31'b0, result_valid}, 1);
    endtask

    task automatic check_writes(input warr_t w, input int rv_cyc);
        chk("write_count", wq.size(), 12);
        for (int i = 0; i < 12 && i < wq.size(); i++) begin
            chk($sformatf("sel[%0d]", i), {30'b0, wq[i].sel}, i / 4);
            chk($sformatf("adr[%0d]", i), {30'b0, wq[i].a}, i % 4);
            chk($sformatf("w2[%0d]", i), {11'b0, wq[i].w}, {11'b0, w[i]});
            if (i > 0) chk($sformatf("gap[%0d]", i), {31'b0, (wq[i].c - wq[i-1].c) > 1}, 1);
        end
`ifndef MATRIX_LOADER_CHECKSUM_EN
        if (wq.size() == 12) chk("latency", rv_cyc - wq[11].c, 4);
`endif
        chk("err_clear", {31'b0, err}, 0);
    endtask

    warr_t w_basic, w_sign;
    barr_t b_basic, b_sign;
    int rvc;

    initial begin
        w_basic = '{21'd1, 21'd2, 21'd3, 21'd4, 21'd1, 21'd0, 21'd0, 21'd1, 21'd1, 21'd0, 21'd0, 21'd1};
        w_sign  = '{21'h1FFFFF, 21'h001234, 21'd0, 21'd0, 21'd0, 21'd0, 21'd0, 21'd0, 21'd0, 21'd0, 21'd0, 21'd0};
        b_basic = mk(w_basic);
        b_sign  = mk(w_sign);
        b_sign[0] = 8'hFF; b_sign[1] = 8'hFF; b_sign[2] = 8'hFF;
        b_sign[3] = 8'h34; b_sign[4] = 8'h12; b_sign[5] = 8'hE0;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; decision_in = 3'b101;
        #12;
        chk("rst_in_ready", {31'b0, in_ready}, 0);
        chk("rst_mat_sel", {30'b0, mat_sel}, 3);
        chk("rst_adr", {30'b0, adr}, 0);
        chk("rst_w2", {11'b0, w2}, 0);
        chk("rst_result", {29'b0, result}, 0);
        chk("rst_rv", {31'b0, result_valid}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_err", {31'b0, err}, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of RECV after one write has gone out.
        xsum = 8'h00;
        in_data = 8'h55; in_valid = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'h55 + 8'(i));
        rst = 1'b1; #2;
        chk("midrst_in_ready", {31'b0, in_ready}, 0);
        chk("midrst_mat_sel", {30'b0, mat_sel}, 3);
        chk("midrst_w2", {11'b0, w2}, 0);
        chk("midrst_busy", {31'b0, busy}, 0);
        #2; rst = 1'b0;
        @(posedge clk); #1;

        run(b_basic, 1'b0, -1, 1'b0, rvc);
        check_writes(w_basic, rvc);
        chk("basic_result", {29'b0, result}, 3'b101);
        repeat (3) @(posedge clk); #1;
        chk("rv_hold", {31'b0, result_valid}, 1);
        chk("idle_busy", {31'b0, busy}, 0);

        decision_in = 3'b010;
        run(b_sign, 1'b0, -1, 1'b0, rvc);
        check_writes(w_sign, rvc);
        chk("sign_result", {29'b0, result}, 3'b010);

        decision_in = 3'b110;
        run(b_basic, 1'b1, -1, 1'b0, rvc);
        check_writes(w_basic, rvc);
        chk("stall_result", {29'b0, result}, 3'b110);

        decision_in = 3'b011;
        run(b_basic, 1'b0, 7, 1'b1, rvc);
        check_writes(w_basic, rvc);
        chk("ignstart_result", {29'b0, result}, 3'b011);

`ifdef MATRIX_LOADER_CHECKSUM_EN
        xsum = 8'h00; wq.delete();
        in_data = b_basic[0]; in_valid = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int i = 0; i < 36; i++) send_byte(b_basic[i]);
        send_byte(xsum ^ 8'h01);
        chk("csum_err", {31'b0, err}, 1);
        chk("csum_rv", {31'b0, result_valid}, 0);
        chk("csum_busy", {31'b0, busy}, 0);
        chk("csum_writes", wq.size(), 12);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
